// File: rtl/brch_pkg.sv
// Shared widths, defaults and the branch entry record for the branch position table.
package brch_pkg;

   localparam int NUM_ENTRIES_DEF = 4;
   localparam int BR_IDX_W_DEF    = 6;
   localparam int POS_W_DEF       = 7;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_width(NUM_ENTRIES_DEF);

   typedef struct packed {
      logic                    vld;
      logic [BR_IDX_W_DEF-1:0] indx;
      logic [POS_W_DEF-1:0]    pos;
   } brch_entry_t;

endpackage

// File: rtl/brch_slot_calc.sv
// Per-slot branch index, ROB position and allocation request for one dispatch group.
module brch_slot_calc #(
   parameter int DISP_WIDTH = 4,
   parameter int BR_IDX_W   = 6,
   parameter int POS_W      = 7
) (
   input  logic [DISP_WIDTH-1:0]                inst_is_brch,
   input  logic [DISP_WIDTH-1:0]                inst_vld,
   input  logic [DISP_WIDTH-1:0]                pr_need_inst,
   input  logic [BR_IDX_W-1:0]                  nxt_indx,
   input  logic [POS_W-1:0]                     curr_pos,
   output logic [DISP_WIDTH-1:0][BR_IDX_W-1:0]  slot_indx,
   output logic [DISP_WIDTH-1:0][POS_W-1:0]     slot_pos,
   output logic [DISP_WIDTH-1:0]                slot_req
);

   logic [DISP_WIDTH-1:0] below;
   logic [POS_W-1:0]      ofs;

   always_comb begin
      slot_indx = '0;
      slot_pos  = '0;
      below     = '0;
      ofs       = '0;
      for (int k = 0; k < DISP_WIDTH; k++) begin
         // only slots strictly below k consume ROB entries ahead of slot k
         below = pr_need_inst & ((DISP_WIDTH'(1) << k) - DISP_WIDTH'(1));
         ofs   = '0;
         for (int b = 0; b < DISP_WIDTH; b++) begin
            ofs = ofs + POS_W'(below[b]);
         end
         slot_indx[k] = nxt_indx + BR_IDX_W'(k);
         slot_pos[k]  = curr_pos + ofs;
      end
   end

   assign slot_req = inst_vld & inst_is_brch;

endmodule

// File: rtl/brch_ckpt_table.sv
// Branch position table: records ROB positions of in-flight branches, frees on commit,
// and squashes a mispredicted branch plus every younger entry using an age matrix.
module brch_ckpt_table
   import brch_pkg::*;
#(
   parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
   parameter int DISP_WIDTH  = 4,
   parameter int BR_IDX_W    = BR_IDX_W_DEF,
   parameter int POS_W       = POS_W_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DISP_WIDTH-1:0]              inst_is_brch,
   input  logic [DISP_WIDTH-1:0]              inst_vld,
   input  logic [BR_IDX_W-1:0]                nxt_indx,
   input  logic [POS_W-1:0]                   curr_pos,
   input  logic [DISP_WIDTH-1:0]              pr_need_inst,
   input  logic                               cmt_brch,
   input  logic [BR_IDX_W-1:0]                cmt_brch_indx,
   input  logic                               mis_pred,
   input  logic [BR_IDX_W-1:0]                brch_mis_indx,
   output logic                               alloc_stall,
   output logic [cnt_width(NUM_ENTRIES)-1:0]  free_cnt,
   output logic                               flush,
   output logic [POS_W-1:0]                   flush_pos,
   output logic                               flush_hit,
   output logic                               all_nop_from_branchUnit
);

   localparam int CNT_W = cnt_width(NUM_ENTRIES);
   localparam int REQ_W = $clog2(DISP_WIDTH + 1);

   logic [DISP_WIDTH-1:0][BR_IDX_W-1:0] slot_indx;
   logic [DISP_WIDTH-1:0][POS_W-1:0]    slot_pos;
   logic [DISP_WIDTH-1:0]               slot_req;

   brch_slot_calc #(
      .DISP_WIDTH (DISP_WIDTH),
      .BR_IDX_W   (BR_IDX_W),
      .POS_W      (POS_W)
   ) u_slot_calc (
      .inst_is_brch (inst_is_brch),
      .inst_vld     (inst_vld),
      .pr_need_inst (pr_need_inst),
      .nxt_indx     (nxt_indx),
      .curr_pos     (curr_pos),
      .slot_indx    (slot_indx),
      .slot_pos     (slot_pos),
      .slot_req     (slot_req)
   );

   brch_entry_t            ent [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] yng [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] vld;

   logic [REQ_W-1:0]       nreq;
   logic [NUM_ENTRIES-1:0] cmt_oh, mis_oh, squash, clr;
   logic                   c_found, m_found;
   logic [POS_W-1:0]       mis_pos;

   logic                   do_alloc, placed;
   logic [NUM_ENTRIES-1:0] alloc_we, taken, row_acc, vld_nxt;
   logic [BR_IDX_W-1:0]    new_indx [NUM_ENTRIES];
   logic [POS_W-1:0]       new_pos  [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] new_row  [NUM_ENTRIES];
   logic [CNT_W-1:0]       nxt_free;

   always_comb begin
      vld = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) vld[i] = ent[i].vld;
   end

   always_comb begin
      nreq = '0;
      for (int k = 0; k < DISP_WIDTH; k++) nreq = nreq + REQ_W'(slot_req[k]);
   end

   assign alloc_stall = int'(nreq) > int'(free_cnt);

   // first valid match wins for both commit and mispredict lookups
   always_comb begin
      cmt_oh  = '0;
      mis_oh  = '0;
      c_found = 1'b0;
      m_found = 1'b0;
      mis_pos = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (ent[i].vld && ent[i].indx == cmt_brch_indx && !c_found) begin
            cmt_oh[i] = cmt_brch;
            c_found   = 1'b1;
         end
         if (ent[i].vld && ent[i].indx == brch_mis_indx && !m_found) begin
            mis_oh[i] = 1'b1;
            mis_pos   = ent[i].pos;
            m_found   = 1'b1;
         end
      end
   end

   assign flush                   = mis_pred;
   assign all_nop_from_branchUnit = mis_pred;
   assign flush_hit               = mis_pred & m_found;
   assign flush_pos               = flush_hit ? mis_pos : '0;

   always_comb begin
      squash = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         squash[i] = mis_pred & ent[i].vld & (mis_oh[i] | (|(yng[i] & mis_oh)));
      end
      clr = squash | cmt_oh;
   end

   // Slots claim the lowest free entries in slot order; each new row records every entry
   // already live plus the ones claimed by lower slots in this same group.
   always_comb begin
      do_alloc = ~alloc_stall & ~mis_pred;
      alloc_we = '0;
      taken    = '0;
      row_acc  = vld;
      placed   = 1'b0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
         new_indx[j] = '0;
         new_pos[j]  = '0;
         new_row[j]  = '0;
      end
      for (int k = 0; k < DISP_WIDTH; k++) begin
         placed = 1'b0;
         if (slot_req[k] && do_alloc) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
               if (!placed && !vld[j] && !taken[j]) begin
                  placed      = 1'b1;
                  taken[j]    = 1'b1;
                  alloc_we[j] = 1'b1;
                  new_indx[j] = slot_indx[k];
                  new_pos[j]  = slot_pos[k];
                  new_row[j]  = row_acc;
                  row_acc[j]  = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      vld_nxt  = (vld & ~clr) | alloc_we;
      nxt_free = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) nxt_free = nxt_free + CNT_W'(!vld_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent[i] <= '0;
            yng[i] <= '0;
         end
         free_cnt <= CNT_W'(NUM_ENTRIES);
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc_we[i]) begin
               ent[i] <= '{vld: 1'b1, indx: new_indx[i], pos: new_pos[i]};
            end else if (clr[i]) begin
               ent[i].vld <= 1'b0;
            end
            for (int j = 0; j < NUM_ENTRIES; j++) begin
               if (alloc_we[i]) begin
                  yng[i][j] <= new_row[i][j];
               end else if (alloc_we[j]) begin
                  yng[i][j] <= 1'b0;
               end
            end
         end
         free_cnt <= nxt_free;
      end
   end

endmodule

// File: doc/brch_ckpt_table.md
Name: brch_ckpt_table

Overview:
Parametrised branch position table for the dispatch stage. Records ROB pointer positions for up to NUM_ENTRIES in-flight branches, with up to DISP_WIDTH new branches per cycle. Frees an entry on branch commit. On mispredict it returns the flush pointer, squashes the mispredicted branch and every younger entry, and tracks entry age so the squash is exact. Sits between decode/dispatch and the ROB/flush logic.

Parameters:
NUM_ENTRIES, 4, number of branch entries (2..16)
DISP_WIDTH, 4, instructions presented per cycle
BR_IDX_W, 6, branch index width; wraps modulo 2^BR_IDX_W
POS_W, 7, ROB pointer position width; wraps modulo 2^POS_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_is_brch  in  DISP_WIDTH  bit k set: slot k is a branch (decoded upstream)
inst_vld  in  DISP_WIDTH  slot k holds a real instruction
nxt_indx  in  BR_IDX_W  branch index of slot 0
curr_pos  in  POS_W  ROB position of slot 0
pr_need_inst  in  DISP_WIDTH  slot k consumes a ROB entry
cmt_brch  in  1  a branch commits this cycle
cmt_brch_indx  in  BR_IDX_W  index of the committing branch
mis_pred  in  1  mispredict reported this cycle
brch_mis_indx  in  BR_IDX_W  index of the mispredicted branch
alloc_stall  out  1  not enough free entries; no branch in this group is allocated
free_cnt  out  $clog2(NUM_ENTRIES+1)  registered count of free entries
flush  out  1  flush request
flush_pos  out  POS_W  ROB position to flush from
flush_hit  out  1  brch_mis_indx matched a valid entry
all_nop_from_branchUnit  out  1  convert the dispatch group to NOPs

Behaviour:
- Entry state: vld, indx[BR_IDX_W], pos[POS_W]. Age matrix yng[i][j] = entry i allocated after entry j.
- Reset: all vld=0, age matrix 0, free_cnt=NUM_ENTRIES. Outputs: flush=0, flush_hit=0, flush_pos=0, alloc_stall=0, all_nop=0. Reset asserted mid-operation discards all entries immediately.
- Slot k branch index = nxt_indx+k, mod 2^BR_IDX_W.
- Slot k position = curr_pos + popcount(pr_need_inst[k-1:0]), mod 2^POS_W. Slot 0 uses curr_pos.
- Requesting slot: inst_vld[k] & inst_is_brch[k]. nreq = number of requesting slots.
- alloc_stall (combinational) = nreq > free_cnt. All-or-nothing: on a stall, nothing is written.
- Allocation at the clock edge: requesting slots, in ascending k, take the lowest-numbered free entries. A new entry's yng row = current vld vector, OR'd with entries allocated this cycle by lower slots. Each column j of existing rows is cleared when entry j is (re)allocated.
- Commit: if cmt_brch, the first valid entry with indx==cmt_brch_indx is cleared at the edge. No match: ignored, no error. Commit by index match happens in any age order.
- Mispredict, 0-cycle, combinational: flush=mis_pred and all_nop=mis_pred. flush_pos = pos of the matching valid entry, with flush_hit=1. On a miss: flush_pos=0, flush_hit=0, flush still 1.
- Mispredict at the edge: clear the matching entry m and every valid i with yng[i][m]=1. Allocation is suppressed that cycle regardless of alloc_stall. Older entries stay untouched.
- Simultaneous commit and mispredict: both apply, clear set = union. If both name the same entry, the entry is cleared once.
- Commit and allocate in the same cycle: the freed entry becomes available the next cycle. free_cnt is from registered state only.
- Full: free_cnt=0 and any branch requests produce alloc_stall=1. Non-branch groups never stall.
- free_cnt updates one cycle after any allocation or clear.

Decomposition:
- Shared package brch_pkg holds:
  - the BR_IDX_W and POS_W defaults
  - the entry struct type {vld, indx, pos}
  - the NUM_ENTRIES default and a count-width constant
- Sub-module brch_slot_calc (combinational) produces per-slot indx, pos and request vector from nxt_indx, curr_pos, pr_need_inst, inst_is_brch and inst_vld.
- Free-entry picking and the age matrix stay in the top level.

Test Plan:
- Reset, then slot 0 branch, nxt_indx=5, curr_pos=10 -> next cycle entry0 {5,10}, free_cnt=3.
- Four branches, pr_need_inst=4'b1111, nxt_indx=62, curr_pos=126, table empty -> entries hold indx 62,63,0,1 and pos 126,127,0,1. free_cnt=0.
- Table full, one more branch -> alloc_stall=1, no entry changed. Same cycle cmt_brch indx 62 -> free_cnt=1 next cycle, and the branch then allocates.
- Allocate indx 3,4,5 in successive cycles, then mis_pred indx 4 -> same cycle flush=1, flush_hit=1, flush_pos=pos(4). Next cycle only indx 3 is valid.
- mis_pred with an unmatched index -> flush=1, flush_hit=0, flush_pos=0, no entries cleared.
- mis_pred indx 3 and cmt_brch indx 2 in the same cycle, with a branch also requesting -> entries 2 through 5 cleared, no allocation that cycle, free_cnt=4.
